regfile_burst_reader: RTL and testbench

//  Read-side sequencer for the 4-word register file. Takes a start command

---
 rtl/regfile_burst_reader_if.sv | 28 ++
 rtl/regfile_burst_reader.sv | 119 +++++++++++
 tb/tb_regfile_burst_reader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_burst_reader_if.sv
// Command, register-file read port and consumer handshake for regfile_burst_reader.
// slave is the reader's view; master is the surrounding logic (command source, file, consumer).
interface regfile_burst_reader_if #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned ADDR_W = 2
);
   logic                      start;
   logic [ADDR_W-1:0]         base;
   logic [ADDR_W:0]           len;
   logic [ADDR_W-1:0]         msel;
   logic [WIDTH-1:0]          q;
   logic [WIDTH-1:0]          dout;
   logic                      valid;
   logic                      ready;
   logic                      busy;
   logic                      done;
   logic [WIDTH+ADDR_W-1:0]   sum;

   modport master (
      output start, base, len, q, ready,
      input  msel, dout, valid, busy, done, sum
   );

   modport slave (
      input  start, base, len, q, ready,
      output msel, dout, valid, busy, done, sum
   );
endinterface

// File: rtl/regfile_burst_reader.sv
// Burst read sequencer for the register file: walks msel from base, hands words out over valid/ready.
// Optional running sum of handed-off words enabled by `define READ_SUM_EN.
module regfile_burst_reader #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned ADDR_W = 2
) (
   input logic                   clk,
   input logic                   clr,
   regfile_burst_reader_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned SUM_W = WIDTH + ADDR_W;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   remaining, remaining_nx;
   logic [ADDR_W-1:0]  msel_r, msel_nx;
   logic [WIDTH-1:0]   dout_r, dout_nx;
   logic               valid_r, valid_nx;
   logic               busy_r, busy_nx;
   logic               done_r, done_nx;

   // State and output registers; the file updates on the falling edge, so do we.
   always_ff @(negedge clk or negedge clr) begin
      if (!clr) begin
         state     <= IDLE;
         remaining <= '0;
         msel_r    <= '0;
         dout_r    <= '0;
         valid_r   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state     <= state_nx;
         remaining <= remaining_nx;
         msel_r    <= msel_nx;
         dout_r    <= dout_nx;
         valid_r   <= valid_nx;
         busy_r    <= busy_nx;
         done_r    <= done_nx;
      end
   end

   // Next state and next register values.
   always_comb begin
      state_nx     = state;
      remaining_nx = remaining;
      msel_nx      = msel_r;
      dout_nx      = dout_r;
      valid_nx     = valid_r;
      busy_nx      = busy_r;
      done_nx      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               busy_nx      = 1'b1;
               remaining_nx = (bus.len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.len;
               if (bus.len == '0) begin
                  done_nx  = 1'b1;
                  state_nx = DONE;
               end else begin
                  msel_nx  = bus.base;
                  state_nx = FETCH;
               end
            end
         end
         FETCH: begin
            dout_nx  = bus.q;
            valid_nx = 1'b1;
            state_nx = HOLD;
         end
         HOLD: begin
            if (valid_r && bus.ready) begin
               valid_nx     = 1'b0;
               remaining_nx = remaining - CNT_W'(1);
               if (remaining == CNT_W'(1)) begin
                  done_nx  = 1'b1;
                  state_nx = DONE;
               end else begin
                  msel_nx  = msel_r + ADDR_W'(1);
                  state_nx = FETCH;
               end
            end
         end
         DONE: begin
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.msel  = msel_r;
   assign bus.dout  = dout_r;
   assign bus.valid = valid_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;

`ifdef READ_SUM_EN
   logic [SUM_W-1:0] sum_r;

   // Running sum, cleared by an accepted start, wraps at 2**SUM_W.
   always_ff @(negedge clk or negedge clr) begin
      if (!clr) begin
         sum_r <= '0;
      end else if (state == IDLE && bus.start) begin
         sum_r <= '0;
      end else if (state == HOLD && valid_r && bus.ready) begin
         sum_r <= sum_r + SUM_W'(dout_r);
      end
   end

   assign bus.sum = sum_r;
`else
   assign bus.sum = '0;
`endif
endmodule

// File: tb/tb_regfile_burst_reader.sv
// Self-checking bench for regfile_burst_reader: transaction-level scoreboard plus directed literal checks.
// Compile with +define+READ_SUM_EN to check the running-sum option.
module tb_regfile_burst_reader;
   localparam int unsigned WIDTH  = 4;
   localparam int unsigned ADDR_W = 2;
   localparam int          DEPTH  = 4;
`ifdef READ_SUM_EN
   localparam bit SUM_ON = 1'b1;
`else
   localparam bit SUM_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic clr;
   logic [WIDTH-1:0] mem [DEPTH];

   regfile_burst_reader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   regfile_burst_reader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.q = mem[bus.msel];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
   endtask

   // Consumer ready: 0 = always ready, 1 = random, 2 = stalled.
   int rdy_mode = 0;
   always @(negedge clk) begin
      #1;
      case (rdy_mode)
         0:       bus.ready = 1'b1;
         1:       bus.ready = ($urandom_range(0, 3) != 0);
         default: bus.ready = 1'b0;
      endcase
   end

   // Reference model: words still owed in this burst, expected sum, and done/busy expectations.
   int exp_addr[$];
   int exp_data[$];
   int got_a[$];
   int got_d[$];
   bit m_active;
   bit m_done_exp;
   int m_gap;
   int m_sum;
   int done_cnt = 0;
   int busy_cyc = 0;

   always @(posedge clk) begin : compare
      bit v_exp;
      int n;
      if (!clr) begin
         exp_addr.delete();
         exp_data.delete();
         m_active   = 1'b0;
         m_done_exp = 1'b0;
         m_gap      = 0;
         m_sum      = 0;
         check("rst_valid", int'(bus.valid), 0);
         check("rst_busy",  int'(bus.busy),  0);
         check("rst_done",  int'(bus.done),  0);
         check("rst_sum",   int'(bus.sum),   0);
      end else begin
         m_gap++;
         // A word is due two edges after the start or the previous handoff.
         v_exp = m_active && !m_done_exp && (exp_addr.size() > 0) && (m_gap >= 2);
         check("busy",  int'(bus.busy),  int'(m_active));
         check("done",  int'(bus.done),  int'(m_done_exp));
         check("valid", int'(bus.valid), int'(v_exp));
         check("sum",   int'(bus.sum),   SUM_ON ? m_sum : 0);
         if (v_exp) begin
            check("msel", int'(bus.msel), exp_addr[0]);
            check("dout", int'(bus.dout), exp_data[0]);
         end
         if (bus.valid && bus.ready) begin
            got_a.push_back(int'(bus.msel));
            got_d.push_back(int'(bus.dout));
         end
         if (bus.done) done_cnt++;
         if (bus.busy) busy_cyc++;

         if (m_done_exp) begin
            m_done_exp = 1'b0;
            m_active   = 1'b0;
         end else if (!m_active && bus.start) begin
            n = (int'(bus.len) > DEPTH) ? DEPTH : int'(bus.len);
            for (int i = 0; i < n; i++) begin
               exp_addr.push_back((int'(bus.base) + i) % DEPTH);
               exp_data.push_back(int'(mem[(int'(bus.base) + i) % DEPTH]));
            end
            m_sum    = 0;
            m_active = 1'b1;
            m_gap    = 0;
            if (n == 0) m_done_exp = 1'b1;
         end else if (v_exp && bus.ready) begin
            m_sum = (m_sum + exp_data[0]) % 64;
            void'(exp_addr.pop_front());
            void'(exp_data.pop_front());
            m_gap = 0;
            if (exp_addr.size() == 0) m_done_exp = 1'b1;
         end
      end
   end

   task automatic start_burst(input int b, input int l);
      @(negedge clk); #1;
      bus.start = 1'b1;
      bus.base  = ADDR_W'(b);
      bus.len   = 3'(l);
      @(negedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic start_pulse();
      @(negedge clk); #1;
      bus.start = 1'b1;
      bus.len   = 3'(4);
      @(negedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("burst_done_seen", int'(done_cnt != d0), 1);
   endtask

   task automatic clear_got();
      got_a.delete();
      got_d.delete();
   endtask

   int d0, b0, n;

   initial begin
      clr       = 1'b0;
      bus.start = 1'b0;
      bus.base  = '0;
      bus.len   = '0;
      mem[0] = 4'h3; mem[1] = 4'hA; mem[2] = 4'h5; mem[3] = 4'hF;
      #2;
      check("init_valid", int'(bus.valid), 0);
      check("init_busy",  int'(bus.busy),  0);
      check("init_msel",  int'(bus.msel),  0);
      check("init_dout",  int'(bus.dout),  0);
      @(negedge clk); #1;
      clr = 1'b1;
      @(negedge clk);

      // Full burst from word 0.
      clear_got(); rdy_mode = 0; d0 = done_cnt;
      start_burst(0, 4);
      wait_done(d0);
      check("t1_words", got_d.size(), 4);
      check("t1_d0", got_d[0], 4'h3);
      check("t1_d1", got_d[1], 4'hA);
      check("t1_d2", got_d[2], 4'h5);
      check("t1_d3", got_d[3], 4'hF);
      check("t1_a3", got_a[3], 3);
      check("t1_sum", int'(bus.sum), SUM_ON ? 'h21 : 0);
      repeat (3) @(posedge clk);
      #1;
      check("t1_sum_hold", int'(bus.sum), SUM_ON ? 'h21 : 0);
      check("t1_one_done", done_cnt - d0, 1);

      // Wrap from word 3 to word 0.
      clear_got(); d0 = done_cnt;
      start_burst(3, 2);
      wait_done(d0);
      check("t2_a0", got_a[0], 3);
      check("t2_a1", got_a[1], 0);
      check("t2_d0", got_d[0], 4'hF);
      check("t2_d1", got_d[1], 4'h3);

      // Consumer stalls on the first word.
      clear_got(); rdy_mode = 2; d0 = done_cnt;
      start_burst(0, 1);
      n = 0;
      while (!bus.valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check("t3_stall_valid", int'(bus.valid), 1);
         check("t3_stall_dout",  int'(bus.dout),  4'h3);
         check("t3_stall_msel",  int'(bus.msel),  0);
         @(posedge clk); #1;
      end
      rdy_mode = 0;
      wait_done(d0);
      check("t3_word", got_d[0], 4'h3);

      // Empty burst.
      clear_got(); d0 = done_cnt; b0 = busy_cyc;
      start_burst(2, 0);
      wait_done(d0);
      repeat (2) @(posedge clk);
      #1;
      check("t4_busy_cycles", busy_cyc - b0, 1);
      check("t4_done_pulses", done_cnt - d0, 1);
      check("t4_no_words", got_d.size(), 0);

      // Asynchronous reset mid-burst.
      clear_got(); rdy_mode = 0;
      start_burst(0, 4);
      n = 0;
      while (got_d.size() < 2 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(negedge clk); #3;
      clr = 1'b0;
      #1;
      check("t5_valid", int'(bus.valid), 0);
      check("t5_busy",  int'(bus.busy),  0);
      check("t5_msel",  int'(bus.msel),  0);
      check("t5_dout",  int'(bus.dout),  0);
      check("t5_sum",   int'(bus.sum),   0);
      repeat (2) @(negedge clk);
      #1;
      clr = 1'b1;
      clear_got(); d0 = done_cnt;
      start_burst(1, 1);
      wait_done(d0);
      check("t5_after_rst", got_d[0], 4'hA);

      // Over-long burst with a stray start while busy.
      clear_got(); d0 = done_cnt;
      start_burst(0, 7);
      start_pulse();
      wait_done(d0);
      repeat (6) @(posedge clk);
      #1;
      check("t6_words", got_d.size(), 4);
      check("t6_done_pulses", done_cnt - d0, 1);

      // Randomized bursts, random consumer, file rewritten between bursts.
      rdy_mode = 1;
      for (int it = 0; it < 40; it++) begin
         int b, l;
         for (int w = 0; w < DEPTH; w++) mem[w] = WIDTH'($urandom);
         b = $urandom_range(0, 3);
         l = $urandom_range(0, 7);
         d0 = done_cnt;
         start_burst(b, l);
         if (l >= 2 && $urandom_range(0, 1) == 1) start_pulse();
         wait_done(d0);
         repeat (2) @(posedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
      $fatal(1);
   end
endmodule
